uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver. It supports configurable data width, parity and stop-bit count. Each bit is decided by a 3-sample majority vote. The block reports parity, framing, break and overrun conditions, and delivers each received word over a valid/ready handshake with a held output register. It sits between the board RX pin and the SHA-256 input loader.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx_param.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding, parity modes and helpers for uart_rx_param
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic logic f_majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    // Data is zero-extended to 9 bits; extra zeros leave the XOR unchanged.
    function automatic logic f_parity_err(input logic [8:0] data, input logic pbit, input int mode);
        logic x;
        x = (^data) ^ pbit;
        if (mode == PARITY_ODD)  return ~x;
        if (mode == PARITY_EVEN) return x;
        return 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// uart_rx_sampler : two-flop synchronizer, 3-sample history, majority vote
// and falling-edge detect for the serial line.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_serial,
    output logic o_line,
    output logic o_fall,
    output logic o_vote
);

    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_hist;

    // Idle-high reset values keep the line looking quiet after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 3'b111;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[1:0], r_sync2};
        end
    end

    assign o_line = r_sync2;
    assign o_fall = r_hist[0] & ~r_sync2;
    assign o_vote = f_majority3(r_hist);

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param : parametrised UART receiver (5..9 data bits, parity, 1/2 stop)
// with error/break/overrun reporting and a valid/ready output register. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Rx_Serial_in,
    input  logic                 Rx_Ready_in,
    output logic                 Rx_Valid_out,
    output logic [DATA_BITS-1:0] Rx_Data_out,
    output logic                 Parity_Err_out,
    output logic                 Frame_Err_out,
    output logic                 Break_out,
    output logic                 Overrun_out,
    output logic                 Busy_out
);

    localparam int             c_CW        = $clog2(CLKS_PER_BIT);
    localparam int             c_IW        = $clog2(DATA_BITS);
    localparam logic [c_CW-1:0] c_MID      = c_CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);
    localparam logic           c_STOP_LAST = 1'(STOP_BITS - 1);

    logic w_line, w_fall, w_vote;

    uart_rx_sampler u_sampler (
        .clk      (CLK),
        .rst_n    (RST_N),
        .i_serial (Rx_Serial_in),
        .o_line   (w_line),
        .o_fall   (w_fall),
        .o_vote   (w_vote)
    );

    rx_state_t              r_state, w_next;
    logic [c_CW-1:0]        r_cnt;
    logic [c_IW-1:0]        r_idx;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_pbit;
    logic                   r_ferr;
    logic                   r_done, r_done_perr, r_done_ferr;
    logic                   r_valid, r_perr_out, r_ferr_out, r_break, r_ovr, r_busy;
    logic [DATA_BITS-1:0]   r_data;

    logic w_cnt_clr, w_store_bit, w_store_par, w_stop_smpl, w_finish, w_brk;
    logic w_tick_bit, w_xfer;

    assign w_tick_bit = (r_cnt == c_LAST);

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_store_bit = 1'b0;
        w_store_par = 1'b0;
        w_stop_smpl = 1'b0;
        w_finish    = 1'b0;
        w_brk       = 1'b0;
        case (r_state)
            S_WAIT_HIGH: if (w_line) w_next = S_IDLE;
            S_IDLE: begin
                if (w_fall) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_START;
                end
            end
            S_START: begin
                if (r_cnt == c_MID) begin
                    w_cnt_clr = 1'b1;
                    w_next    = w_vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_bit) begin
                    w_cnt_clr   = 1'b1;
                    w_store_bit = 1'b1;
                    if (r_idx == c_IDX_LAST)
                        w_next = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick_bit) begin
                    w_cnt_clr   = 1'b1;
                    w_store_par = 1'b1;
                    w_next      = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick_bit) begin
                    w_cnt_clr   = 1'b1;
                    w_stop_smpl = 1'b1;
                    // Break: all-zero data, zero parity (if any), first stop zero.
                    if (!r_stop_idx && !w_vote && (r_shift == '0) &&
                        ((PARITY_MODE == PARITY_NONE) || !r_pbit)) begin
                        w_brk  = 1'b1;
                        w_next = S_WAIT_HIGH;
                    end else if (r_stop_idx == c_STOP_LAST) begin
                        w_finish = 1'b1;
                        w_next   = (r_ferr || !w_vote) ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            default: w_next = S_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_WAIT_HIGH;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_pbit      <= 1'b0;
            r_ferr      <= 1'b0;
            r_done      <= 1'b0;
            r_done_perr <= 1'b0;
            r_done_ferr <= 1'b0;
            r_break     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            if (w_cnt_clr || r_state == S_IDLE || r_state == S_WAIT_HIGH)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_START) begin
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (w_store_bit) begin
                r_shift[r_idx] <= w_vote;
                r_idx          <= r_idx + 1'b1;
            end
            if (w_store_par)
                r_pbit <= w_vote;
            if (w_stop_smpl) begin
                r_stop_idx <= r_stop_idx + 1'b1;
                if (!w_vote) r_ferr <= 1'b1;
            end
            r_done  <= w_finish;
            r_break <= w_brk;
            if (w_finish) begin
                r_done_ferr <= r_ferr | ~w_vote;
                r_done_perr <= f_parity_err(9'(r_shift), r_pbit, PARITY_MODE);
            end
        end
    end

    assign w_xfer = r_valid & Rx_Ready_in;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ovr <= r_done & r_valid & ~Rx_Ready_in;
            if (r_done && (!r_valid || w_xfer)) begin
                r_valid    <= 1'b1;
                r_data     <= r_shift;
                r_perr_out <= r_done_perr;
                r_ferr_out <= r_done_ferr;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Rx_Valid_out   = r_valid;
    assign Rx_Data_out    = r_data;
    assign Parity_Err_out = r_perr_out;
    assign Frame_Err_out  = r_ferr_out;
    assign Break_out      = r_break;
    assign Overrun_out    = r_ovr;
    assign Busy_out       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// tb_uart_rx_param : self-checking bench with an 8N1 and an 8E1 receiver.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_param;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rx_n, rx_e, ready;
    logic v_n, pe_n, fe_n, bk_n, ov_n, by_n;
    logic v_e, pe_e, fe_e, bk_e, ov_e, by_e;
    logic [7:0] d_n, d_e;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_n (
        .CLK(clk), .RST_N(rst_n), .Rx_Serial_in(rx_n), .Rx_Ready_in(ready),
        .Rx_Valid_out(v_n), .Rx_Data_out(d_n), .Parity_Err_out(pe_n), .Frame_Err_out(fe_n),
        .Break_out(bk_n), .Overrun_out(ov_n), .Busy_out(by_n));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut_e (
        .CLK(clk), .RST_N(rst_n), .Rx_Serial_in(rx_e), .Rx_Ready_in(ready),
        .Rx_Valid_out(v_e), .Rx_Data_out(d_e), .Parity_Err_out(pe_e), .Frame_Err_out(fe_e),
        .Break_out(bk_e), .Overrun_out(ov_e), .Busy_out(by_e));

    int n_vec = 0;
    int n_err = 0;

    // Observer: collects transferred words {ferr, perr, data} and pulse counts.
    int cyc = 0, rise_cyc = 0, vlen = 0, last_vlen = 0, brk_cnt = 0, ovr_cnt = 0;
    logic v_prev = 1'b0;
    logic [9:0] q_n[$];
    logic [9:0] q_e[$];

    always @(negedge clk) begin
        cyc++;
        if (v_n && !v_prev) rise_cyc = cyc;
        if (v_n) vlen++;
        else if (v_prev) begin last_vlen = vlen; vlen = 0; end
        v_prev = v_n;
        if (v_n && ready) q_n.push_back({fe_n, pe_n, d_n});
        if (v_e && ready) q_e.push_back({fe_e, pe_e, d_e});
        if (bk_n) brk_cnt++;
        if (ov_n) ovr_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: serial frames and expected words from the frame rules.
    function automatic logic [11:0] frame_n(input logic [7:0] d, input logic stop);
        return {2'b00, stop, d, 1'b0};
    endfunction

    function automatic logic [11:0] frame_e(input logic [7:0] d, input logic p);
        return {1'b0, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [9:0] exp_e(input logic [7:0] d, input logic p);
        logic ones;
        ones = ^{d, p};
        return {1'b0, ones, d};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx(input bit sel, input logic [11:0] bits, input int n, input int spike,
                      input logic end_level);
        logic b;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) begin
                b = bits[i];
                if (i * CPB + c == spike) b = ~b;
                if (sel) rx_e = b; else rx_n = b;
                @(posedge clk); #1;
            end
        end
        if (sel) rx_e = end_level; else rx_n = end_level;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1; ready = 1'b1;
        idle(4);
        n_vec++;
        if ({v_n, d_n, pe_n, fe_n, bk_n, ov_n, by_n} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_n: got %h expected 0", {v_n, d_n, pe_n, fe_n, bk_n, ov_n, by_n});
        end
        n_vec++;
        if ({v_e, d_e, pe_e, fe_e, bk_e, ov_e, by_e} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_e: got %h expected 0", {v_e, d_e, pe_e, fe_e, bk_e, ov_e, by_e});
        end
        rst_n = 1'b1;
        idle(8);
        n_vec++;
        if (by_n !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_reset: got %b expected 0", by_n);
        end
    endtask

    task automatic test_8n1;
        int t0, lat;
        q_n.delete();
        t0 = cyc;
        tx(1'b0, frame_n(8'hA5, 1'b1), 10, -1, 1'b1);
        idle(2 * CPB);
        lat = rise_cyc - t0;
        n_vec++;
        if (q_n.size() != 1 || q_n[0] !== {2'b00, 8'hA5}) begin
            n_err++;
            $display("FAIL 8n1_word: got n=%0d w=%h expected n=1 w=%h", q_n.size(),
                     (q_n.size() > 0) ? q_n[0] : 10'h0, {2'b00, 8'hA5});
        end
        n_vec++;
        if (lat < 9 * CPB + CPB / 2 || lat > 9 * CPB + CPB / 2 + 8) begin
            n_err++;
            $display("FAIL 8n1_latency: got %0d cycles expected %0d..%0d", lat,
                     9 * CPB + CPB / 2, 9 * CPB + CPB / 2 + 8);
        end
        n_vec++;
        if (last_vlen != 1) begin
            n_err++;
            $display("FAIL 8n1_valid_width: got %0d expected 1", last_vlen);
        end
    endtask

    task automatic test_parity;
        q_e.delete();
        tx(1'b1, frame_e(8'h03, 1'b0), 11, -1, 1'b1);
        idle(2 * CPB);
        tx(1'b1, frame_e(8'h03, 1'b1), 11, -1, 1'b1);
        idle(2 * CPB);
        n_vec++;
        if (q_e.size() != 2) begin
            n_err++;
            $display("FAIL parity_count: got %0d expected 2", q_e.size());
        end else begin
            n_vec++;
            if (q_e[0] !== exp_e(8'h03, 1'b0)) begin
                n_err++;
                $display("FAIL parity_good: got %h expected %h", q_e[0], exp_e(8'h03, 1'b0));
            end
            n_vec++;
            if (q_e[1] !== exp_e(8'h03, 1'b1)) begin
                n_err++;
                $display("FAIL parity_bad: got %h expected %h", q_e[1], exp_e(8'h03, 1'b1));
            end
        end
    endtask

    task automatic test_frame_err;
        q_n.delete();
        tx(1'b0, frame_n(8'h55, 1'b0), 10, -1, 1'b0);
        idle(3 * CPB);
        n_vec++;
        if (q_n.size() != 1 || q_n[0] !== {1'b1, 1'b0, 8'h55}) begin
            n_err++;
            $display("FAIL frame_word: got n=%0d w=%h expected n=1 w=%h", q_n.size(),
                     (q_n.size() > 0) ? q_n[0] : 10'h0, {1'b1, 1'b0, 8'h55});
        end
        n_vec++;
        if (by_n !== 1'b1) begin
            n_err++;
            $display("FAIL frame_wait_high_busy: got %b expected 1", by_n);
        end
        rx_n = 1'b1;
        idle(6);
        n_vec++;
        if (by_n !== 1'b0 || q_n.size() != 1) begin
            n_err++;
            $display("FAIL frame_release: got busy=%b n=%0d expected busy=0 n=1", by_n, q_n.size());
        end
    endtask

    task automatic test_break;
        int b0;
        b0 = brk_cnt;
        q_n.delete();
        rx_n = 1'b0;
        idle(20 * CPB);
        rx_n = 1'b1;
        idle(2 * CPB);
        n_vec++;
        if (brk_cnt - b0 != 1 || q_n.size() != 0 || v_n !== 1'b0) begin
            n_err++;
            $display("FAIL break: got pulses=%0d words=%0d valid=%b expected 1 0 0",
                     brk_cnt - b0, q_n.size(), v_n);
        end
        tx(1'b0, frame_n(8'h3C, 1'b1), 10, -1, 1'b1);
        idle(2 * CPB);
        n_vec++;
        if (q_n.size() != 1 || q_n[0] !== {2'b00, 8'h3C}) begin
            n_err++;
            $display("FAIL after_break: got n=%0d w=%h expected n=1 w=%h", q_n.size(),
                     (q_n.size() > 0) ? q_n[0] : 10'h0, {2'b00, 8'h3C});
        end
    endtask

    task automatic test_noise;
        q_n.delete();
        rx_n = 1'b0;
        idle(2);
        rx_n = 1'b1;
        idle(3 * CPB);
        n_vec++;
        if (by_n !== 1'b0 || q_n.size() != 0) begin
            n_err++;
            $display("FAIL glitch: got busy=%b words=%0d expected 0 0", by_n, q_n.size());
        end
        tx(1'b0, frame_n(8'hFF, 1'b1), 10, 3 * CPB + CPB / 2, 1'b1);
        idle(2 * CPB);
        n_vec++;
        if (q_n.size() != 1 || q_n[0] !== {2'b00, 8'hFF}) begin
            n_err++;
            $display("FAIL spike: got n=%0d w=%h expected n=1 w=%h", q_n.size(),
                     (q_n.size() > 0) ? q_n[0] : 10'h0, {2'b00, 8'hFF});
        end
    endtask

    task automatic test_back_to_back_overrun;
        int o0;
        q_n.delete();
        ready = 1'b0;
        o0 = ovr_cnt;
        tx(1'b0, frame_n(8'h11, 1'b1), 10, -1, 1'b1);
        tx(1'b0, frame_n(8'h22, 1'b1), 10, -1, 1'b1);
        idle(CPB);
        n_vec++;
        if (v_n !== 1'b1 || d_n !== 8'h11 || ovr_cnt - o0 != 1 || q_n.size() != 0) begin
            n_err++;
            $display("FAIL overrun: got v=%b d=%h pulses=%0d xfers=%0d expected 1 11 1 0",
                     v_n, d_n, ovr_cnt - o0, q_n.size());
        end
        ready = 1'b1;
        idle(1);
        n_vec++;
        if (v_n !== 1'b0 || q_n.size() != 1 || q_n[0] !== {2'b00, 8'h11}) begin
            n_err++;
            $display("FAIL overrun_drain: got v=%b n=%0d expected v=0 n=1 w=%h",
                     v_n, q_n.size(), {2'b00, 8'h11});
        end
    endtask

    task automatic test_reset_mid;
        q_n.delete();
        tx(1'b0, frame_n(8'h5A, 1'b1), 4, -1, 1'b1);
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({v_n, d_n, pe_n, fe_n, bk_n, ov_n, by_n} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_mid: got %h expected 0", {v_n, d_n, pe_n, fe_n, bk_n, ov_n, by_n});
        end
        idle(3);
        rst_n = 1'b1;
        idle(15 * CPB);
        n_vec++;
        if (q_n.size() != 0 || v_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_spurious: got words=%0d valid=%b expected 0 0", q_n.size(), v_n);
        end
    endtask

    task automatic test_random;
        logic [9:0] exp_q[$];
        logic [7:0] d;
        logic p;
        q_n.delete();
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            exp_q.push_back({2'b00, d});
            tx(1'b0, frame_n(d, 1'b1), 10, -1, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(2 * CPB);
        n_vec++;
        if (q_n.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_n_count: got %0d expected %0d", q_n.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (q_n[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_n[%0d]: got %h expected %h", i, q_n[i], exp_q[i]);
                end
            end
        end
        exp_q.delete();
        q_e.delete();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            exp_q.push_back(exp_e(d, p));
            tx(1'b1, frame_e(d, p), 11, -1, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(2 * CPB);
        n_vec++;
        if (q_e.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_e_count: got %0d expected %0d", q_e.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (q_e[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_e[%0d]: got %h expected %h", i, q_e[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_break();
        test_noise();
        test_back_to_back_overrun();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
